// File: rtl/bus_slave_ram.sv
// Bus slave RAM: 2^ADDR_W x 32-bit memory behind a cs_/as_/rdy_ handshake with
// WAIT_CYCLES wait states; rdy_ pulses for one cycle per completed access.
module bus_slave_ram #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rdy_
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [3:0]        count_reg, count_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rw_reg, rw_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rd_data_reg;
    logic              rdy_reg;
    logic              req;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_rw;

    logic [31:0] mem [2**ADDR_W];

    assign req = !cs_ && !as_;

    // With zero wait states READY is entered on the latching edge itself,
    // so the access attributes come straight from the bus in IDLE.
    assign acc_addr = (state_reg == IDLE) ? addr : addr_reg;
    assign acc_rw   = (state_reg == IDLE) ? rw   : rw_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        rw_next    = rw_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    addr_next  = addr;
                    rw_next    = rw;
                    wdata_next = wr_data;
                    count_next = WAIT_LOAD;
                    state_next = (WAIT_CYCLES == 0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count_reg == 4'd0) begin
                    state_next = READY;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            READY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            addr_reg  <= '0;
            rw_reg    <= 1'b1;
            wdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            rw_reg    <= rw_next;
            wdata_reg <= wdata_next;
        end
    end

    // READY is only ever entered from IDLE or WAIT, so state_next == READY marks entry.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            rdy_reg     <= 1'b1;
            rd_data_reg <= 32'd0;
        end else begin
            rdy_reg     <= (state_next != READY);
            rd_data_reg <= (state_next == READY && acc_rw) ? mem[acc_addr] : 32'd0;
        end
    end

    // Memory is not reset, but a reset on the READY-ending edge cancels the write.
    always_ff @(posedge clk) begin
        if (reset_ && state_reg == READY && !rw_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    assign rd_data = rd_data_reg;
    assign rdy_    = rdy_reg;

endmodule
